// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words onto a configuration flip-flop chain and
// returns the bits leaving the chain tail as readback words.
//
// Ports: prog_clk/prog_reset_n clock and async active-low reset;
// start/abort load control pulses; in_valid/in_data/in_ready bitstream
// word stream (MSB shifted first); ccff_head/ccff_shift_en chain drive;
// ccff_tail chain output; rb_valid/rb_data readback words (first tail
// bit in the MSB); busy/done/aborted load status.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int NWORDS = CHAIN_LEN / WORD_W;
  localparam int WL_W   = $clog2(NWORDS + 1);
  localparam int BC_W   = $clog2(WORD_W);

  localparam logic [WL_W-1:0] WL_FULL = WL_W'(NWORDS);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

  if ((CHAIN_LEN % WORD_W) != 0 || WORD_W < 2) begin : g_bad_params
    $error("CHAIN_LEN must be a multiple of WORD_W, WORD_W >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    SHIFT
  } state_t;

  state_t            state;
  logic [WL_W-1:0]   words_left;
  logic [BC_W-1:0]   bit_cnt;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] rb_sh;
  logic              last_bit;
  logic              take;

  assign last_bit = (state == SHIFT) && (bit_cnt == BC_LAST);

  // abort wins over a coincident handshake, so the word stays unconsumed
  assign in_ready = !abort &&
                    ((state == WAIT_WORD) ||
                     (last_bit && (words_left != '0)));

  assign take = in_ready && in_valid;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state         <= IDLE;
      words_left    <= '0;
      bit_cnt       <= '0;
      sreg          <= '0;
      rb_sh         <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      rb_valid      <= 1'b0;
      rb_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      done     <= 1'b0;
      if (abort && (state != IDLE)) begin
        state         <= IDLE;
        words_left    <= '0;
        bit_cnt       <= '0;
        ccff_head     <= 1'b0;
        ccff_shift_en <= 1'b0;
        busy          <= 1'b0;
        aborted       <= 1'b1;
      end else begin
        // tail is sampled before this edge shifts the chain
        if (state == SHIFT) begin
          rb_sh <= {rb_sh[WORD_W-2:0], ccff_tail};
        end
        unique case (state)
          IDLE: begin
            if (start) begin
              words_left <= WL_FULL;
              aborted    <= 1'b0;
              busy       <= 1'b1;
              state      <= WAIT_WORD;
            end
          end
          WAIT_WORD: begin
            if (take) begin
              ccff_head     <= in_data[WORD_W-1];
              sreg          <= in_data << 1;
              bit_cnt       <= '0;
              words_left    <= words_left - WL_W'(1);
              ccff_shift_en <= 1'b1;
              state         <= SHIFT;
            end
          end
          SHIFT: begin
            if (!last_bit) begin
              ccff_head <= sreg[WORD_W-1];
              sreg      <= sreg << 1;
              bit_cnt   <= bit_cnt + BC_W'(1);
            end else begin
              rb_valid <= 1'b1;
              rb_data  <= {rb_sh[WORD_W-2:0], ccff_tail};
              if (take) begin
                ccff_head  <= in_data[WORD_W-1];
                sreg       <= in_data << 1;
                bit_cnt    <= '0;
                words_left <= words_left - WL_W'(1);
              end else if (words_left == '0) begin
                ccff_head     <= 1'b0;
                ccff_shift_en <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
                state         <= IDLE;
              end else begin
                // stream stalled: chain holds until the next word
                ccff_head     <= 1'b0;
                ccff_shift_en <= 1'b0;
                state         <= WAIT_WORD;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with a 32-bit chain model.
// WORD_W=8, CHAIN_LEN=32.
module tb_ccff_bitstream_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_tail;
  logic       rb_valid;
  logic [7:0] rb_data;
  logic       busy;
  logic       done;
  logic       aborted;

  int n_chk = 0;
  int n_fail = 0;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(32)) dut (
    .prog_clk      (clk),
    .prog_reset_n  (rst_n),
    .start         (start),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .rb_valid      (rb_valid),
    .rb_data       (rb_data),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted)
  );

  always #5 clk = ~clk;

  // chain model: shifts head in at bit 0, tail is bit 31
  logic [31:0] chain = '0;
  logic [31:0] pre_v = '0;
  logic        pre_en = 1'b0;
  assign ccff_tail = chain[31];
  always @(posedge clk) begin
    if (pre_en) chain <= pre_v;
    else if (ccff_shift_en) chain <= {chain[30:0], ccff_head};
  end

  // recorder
  logic        clr = 1'b0;
  int          cyc = 0;
  logic [31:0] serial;
  int          nshift;
  int          first_sh;
  int          last_sh;
  logic [31:0] rbw;
  int          nrb;
  int          ndone;
  int          done_cyc;
  logic        busy_at_done;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      serial <= '0; nshift <= 0; first_sh <= -1; last_sh <= 0;
      rbw <= '0; nrb <= 0; ndone <= 0; done_cyc <= 0;
      busy_at_done <= 1'b1;
    end else begin
      if (ccff_shift_en) begin
        serial <= {serial[30:0], ccff_head};
        nshift <= nshift + 1;
        if (first_sh < 0) first_sh <= cyc;
        last_sh <= cyc;
      end
      if (rb_valid) begin
        rbw <= {rbw[23:0], rb_data};
        nrb <= nrb + 1;
      end
      if (done) begin
        ndone <= ndone + 1;
        done_cyc <= cyc;
        busy_at_done <= busy;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] v);
    pre_v = v;
    pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_flags"},
        {25'd0, in_ready, ccff_head, ccff_shift_en, rb_valid,
         busy, done, aborted}, 32'd0);
    chk({tag, "_rb_data"}, {24'd0, rb_data}, 32'd0);
  endtask

  logic [31:0] snap;

  // c counts cycles after the start cycle; ab/st2/rs select the cycle
  // for abort, a second start, or a mid-cycle reset (0 = none)
  task automatic run_load(input logic [31:0] w, input bit gap,
                          input int ab, input int st2, input int rs);
    int idx;
    int hold;
    idx = 0;
    hold = 0;
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      abort = (c == ab);
      start = (c == st2);
      in_valid = (idx < 4) && (hold == 0);
      in_data = (idx < 4) ? w[31 - 8*idx -: 8] : 8'h00;
      if (c == rs) begin
        snap = chain;
        #2 rst_n = 1'b0;
        #1 chk_rst_outs("async_reset");
        break;
      end
      @(negedge clk);
      if (hold > 0) hold--;
      else if (in_ready && in_valid) begin
        idx++;
        if (gap && idx == 2) hold = 13;
      end
      tick();
      if (c == ab || ndone != 0) break;
    end
    abort = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic chk_full(input string tag, input int span);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_nshift"}, nshift, 32);
    chk({tag, "_serial"}, serial, 32'hA53CFF01);
    chk({tag, "_span"}, last_sh - first_sh + 1, span);
    chk({tag, "_nrb"}, nrb, 4);
    chk({tag, "_rb"}, rbw, 32'hDEADBEEF);
    chk({tag, "_done_cyc"}, done_cyc, last_sh + 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    chk({tag, "_chain"}, chain, 32'hA53CFF01);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_aborted"}, aborted, 1'b0);
  endtask

  initial begin
    #3 chk_rst_outs("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", in_ready, 1'b0);

    // gapless load with readback of the previous contents
    preload(32'hDEADBEEF);
    run_load(32'hA53CFF01, 1'b0, 0, 0, 0);
    chk_full("load", 32);

    // stalled stream: 5 idle wait cycles plus the accept cycle
    preload(32'hDEADBEEF);
    run_load(32'hA53CFF01, 1'b1, 0, 0, 0);
    chk_full("gap", 38);

    // abort during the 12th shift cycle
    preload(32'hDEADBEEF);
    run_load(32'hA53CFF01, 1'b0, 13, 0, 0);
    chk("abort_shift_en", ccff_shift_en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_aborted", aborted, 1'b1);
    chk("abort_ready", in_ready, 1'b0);
    repeat (12) tick();
    chk("abort_nshift", nshift, 12);
    chk("abort_serial", serial[11:0], 12'hA53);
    chk("abort_nrb", nrb, 1);
    chk("abort_rb", rbw[7:0], 8'hDE);
    chk("abort_ndone", ndone, 0);
    chk("abort_sticky", aborted, 1'b1);

    preload(32'hDEADBEEF);
    run_load(32'hA53CFF01, 1'b0, 0, 0, 0);
    chk_full("reload", 32);

    // abort while idle, then a start pulse while busy
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("idle_abort_aborted", aborted, 1'b0);
    chk("idle_abort_busy", busy, 1'b0);
    preload(32'hDEADBEEF);
    run_load(32'hA53CFF01, 1'b0, 0, 5, 0);
    chk_full("busy_start", 32);

    // asynchronous reset in the middle of the second word
    preload(32'hDEADBEEF);
    run_load(32'hA53CFF01, 1'b0, 0, 0, 14);
    tick();
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_ready", in_ready, 1'b0);
      chk("post_reset_shift", ccff_shift_en, 1'b0);
    end
    in_valid = 1'b0;
    chk("post_reset_chain", chain, snap);
    chk("post_reset_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
